bram_read_arbiter: RTL and testbench
====================================

# bram_read_arbiter

Round-robin arbiter sharing the single read port of the instruction/character-class BRAM among `N_REQ` regex coprocessor memory clients (e.g. multiple coprocessor instances or fetch units). Each client issues addresses on a valid/ready handshake. The arbiter drives the BRAM read port and routes the read data back to the issuing client after the fixed BRAM latency. It sits between the coprocessor cores and the BRAM inside the AXI-facing top, and gates itself off via `enable` while the host owns the BRAM (write/read commands).

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `ADDR_WIDTH`, 9: BRAM read address width.
- `DATA_WIDTH`, 64: BRAM read data width.
- `BRAM_LATENCY`, 1: cycles from `bram_r_valid` to valid `bram_r` data (1..3).
- `CNT_WIDTH`, 32: stall counter width (used only with `BRAM_ARB_STALL_COUNT_EN`).

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `enable` in 1: high = arbiter owns the BRAM port; low = no new grants.
- `req_valid` in `N_REQ`: per-requester address valid.
- `req_ready` out `N_REQ`: per-requester grant, one-hot or zero.
- `req_addr` in `N_REQ*ADDR_WIDTH`: requester i address at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `resp_valid` out `N_REQ`: one-hot, read data valid for requester i.
- `resp_data` out `DATA_WIDTH`: read data, shared by all requesters.
- `bram_r_addr` out `ADDR_WIDTH`: BRAM read address.
- `bram_r_valid` out 1: BRAM read enable.
- `bram_r` in `DATA_WIDTH`: BRAM read data.
- `stall_count` out `CNT_WIDTH`: present only with `BRAM_ARB_STALL_COUNT_EN`.

## Operation
- Grant logic is combinational from `req_valid`, `enable` and the registered priority pointer `ptr` (`$clog2(N_REQ)` bits, minimum 1).
- When `enable`=1 and any `req_valid` is set, grant the first valid requester scanning `ptr, ptr+1, …, N_REQ-1, 0, …` (wrap modulo `N_REQ`).
- `req_ready[g]`=1 for the granted index only. A transfer completes when `req_valid[g] & req_ready[g]`.
- On a grant: `bram_r_valid`=1 and `bram_r_addr`=`req_addr[g]`. Otherwise `bram_r_valid`=0 and `bram_r_addr`=0.
- After a grant, `ptr` <= g+1, wrapping from `N_REQ-1` to 0. With no grant, `ptr` holds.
- Tag pipeline: `BRAM_LATENCY` stages of `N_REQ`-bit one-hot grant vectors. Stage 0 <= the grant vector; stage k <= stage k-1.
- `resp_valid` = last tag stage. `resp_data` = `bram_r` passed through, unregistered.
- `enable`=0: `req_ready`=0 and `bram_r_valid`=0. In-flight tags still drain and their responses are delivered.
- A requester may hold `req_valid` across cycles. The address must be stable until its grant.
- Reset (`rst`=0 at a clock edge):
  - `ptr` = 0 and all tag stages = 0.
  - `resp_valid` = 0 the next cycle. In-flight responses are dropped.
  - Combinational outputs follow the rules above. `stall_count` = 0.
- Invalid `N_REQ` or `BRAM_LATENCY` values are rejected at elaboration with `$error`.

## Timing
- Address-to-data latency: exactly `BRAM_LATENCY` cycles after the handshake cycle.
- Throughput: one grant per cycle. Back-to-back grants to the same requester are allowed only if no other requester is valid.
- With k requesters continuously valid, each is granted once every k cycles. Worst-case wait is `N_REQ-1` cycles while `enable`=1.
- Responses to different requesters return in grant order, never reordered or merged. At most one `resp_valid` bit is high per cycle.
- `enable` may toggle any cycle. It takes effect combinationally in the same cycle.

## Configuration
- `BRAM_ARB_STALL_COUNT_EN` defined:
  - Adds `stall_count`, a saturating counter.
  - It increments by 1 on every cycle where at least one requester has `req_valid`=1 and `req_ready`=0, whether blocked by `enable`=0 or by losing arbitration.
  - It holds at all-ones and clears only on reset.
- Macro undefined: the `stall_count` port and counter logic do not exist. All other behaviour is identical.

## Test plan
- Reset then idle: `rst`=0 for 2 cycles, `req_valid`=0 → `resp_valid`=0, `bram_r_valid`=0, `req_ready`=0, `stall_count`=0.
- Single requester, `N_REQ`=2, latency 1: req1 addr 0x05, BRAM returns 0xDEAD_BEEF_0000_0005 → `req_ready`=2'b10 in cycle t, `resp_valid`=2'b10 with that data in t+1.
- Fairness: both requesters valid for 6 cycles from reset → grant sequence 0,1,0,1,0,1. Each response arrives one cycle after its grant, tagged to the correct requester.
- Wrap and skip, `N_REQ`=4: only req1 and req3 valid → grants 1,3,1,3. `ptr` wraps 3→0 and req0 and req2 are skipped.
- `enable` drop: grant req0 at t, `enable`=0 at t+1 with req1 valid, `BRAM_LATENCY`=2 → `resp_valid`=req0 at t+2. No grant while disabled. req1 is granted the first cycle `enable`=1. With the macro on, `stall_count` increases once per disabled cycle.
- Reset mid-flight, `BRAM_LATENCY`=3: grant at t, `rst`=0 at t+1 → no `resp_valid` for that grant. The first grant after release goes to requester 0 if valid.

Source files
------------

// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among N_REQ clients, with a one-hot tag pipeline routing data back.
// Optional saturating stall counter (port stall_count_o) exists only when BRAM_ARB_STALL_COUNT_EN is defined.
module bram_read_arbiter #(
  parameter int N_REQ        = 2,
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 64,
  parameter int BRAM_LATENCY = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [N_REQ-1:0]            resp_valid_o,
  output logic [DATA_WIDTH-1:0]       resp_data_o,
  output logic [ADDR_WIDTH-1:0]       bram_r_addr_o,
  output logic                        bram_r_valid_o,
  input  logic [DATA_WIDTH-1:0]       bram_r_i
`ifdef BRAM_ARB_STALL_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]        stall_count_o
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("bram_read_arbiter: N_REQ must be in 2..8");
  end
  if (BRAM_LATENCY < 1 || BRAM_LATENCY > 3) begin : g_bad_latency
    $error("bram_read_arbiter: BRAM_LATENCY must be in 1..3");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("bram_read_arbiter: CNT_WIDTH must be at least 1");
  end

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W:0]        scan_idx;
  logic                  gnt_found;
  logic [N_REQ-1:0]      gnt_vec;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [N_REQ-1:0]      tag_q [BRAM_LATENCY];

  // Scan starts at ptr_q and wraps; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (scan_idx >= (PTR_W+1)'(N_REQ)) begin
        scan_idx = scan_idx - (PTR_W+1)'(N_REQ);
      end
      if (!gnt_found && enable_i && req_valid_i[scan_idx[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_vec  = '0;
    addr_mux = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (gnt_found && (gnt_idx == PTR_W'(j))) begin
        gnt_vec[j] = 1'b1;
        addr_mux   = req_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_found) begin
      ptr_d = (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Tags keep flowing while enable_i is low so in-flight reads still complete.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < BRAM_LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= gnt_vec;
      for (int k = 1; k < BRAM_LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign req_ready_o    = gnt_vec;
  assign bram_r_valid_o = gnt_found;
  assign bram_r_addr_o  = addr_mux;
  assign resp_valid_o   = tag_q[BRAM_LATENCY-1];
  assign resp_data_o    = bram_r_i;

`ifdef BRAM_ARB_STALL_COUNT_EN
  logic                 stall_cycle;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  assign stall_cycle = |(req_valid_i & ~gnt_vec);

  always_comb begin
    stall_d = stall_q;
    if (stall_cycle && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count_o = stall_q;
`endif

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench for bram_read_arbiter: three instances (N=2/L=1, N=4/L=2, N=2/L=3) with simple BRAM models.
module tb_bram_read_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  // Instance A: N_REQ=2, latency 1
  logic        a_en;
  logic [1:0]  a_valid, a_ready, a_resp_valid;
  logic [17:0] a_addr;
  logic [63:0] a_resp_data, a_bram_r;
  logic [8:0]  a_bram_addr;
  logic        a_bram_valid;
  // Instance B: N_REQ=4, latency 2
  logic        b_en;
  logic [3:0]  b_valid, b_ready, b_resp_valid;
  logic [35:0] b_addr;
  logic [63:0] b_resp_data, b_bram_r, b_p1;
  logic [8:0]  b_bram_addr;
  logic        b_bram_valid;
  // Instance C: N_REQ=2, latency 3
  logic        c_en;
  logic [1:0]  c_valid, c_ready, c_resp_valid;
  logic [17:0] c_addr;
  logic [63:0] c_resp_data, c_bram_r, c_p1, c_p2;
  logic [8:0]  c_bram_addr;
  logic        c_bram_valid;
`ifdef BRAM_ARB_STALL_COUNT_EN
  logic [31:0] a_stall, b_stall, c_stall;
`endif

  function automatic logic [63:0] bd(input logic [8:0] a);
    return {32'hDEAD_BEEF, 23'd0, a};
  endfunction

  always @(posedge clk) a_bram_r <= bd(a_bram_addr);
  always @(posedge clk) begin
    b_p1     <= bd(b_bram_addr);
    b_bram_r <= b_p1;
  end
  always @(posedge clk) begin
    c_p1     <= bd(c_bram_addr);
    c_p2     <= c_p1;
    c_bram_r <= c_p2;
  end

  bram_read_arbiter #(.N_REQ(2), .ADDR_WIDTH(9), .DATA_WIDTH(64), .BRAM_LATENCY(1), .CNT_WIDTH(32)) u_a (
    .clk_i(clk), .rst_i(rst_n), .enable_i(a_en), .req_valid_i(a_valid), .req_ready_o(a_ready),
    .req_addr_i(a_addr), .resp_valid_o(a_resp_valid), .resp_data_o(a_resp_data),
    .bram_r_addr_o(a_bram_addr), .bram_r_valid_o(a_bram_valid), .bram_r_i(a_bram_r)
`ifdef BRAM_ARB_STALL_COUNT_EN
    , .stall_count_o(a_stall)
`endif
  );

  bram_read_arbiter #(.N_REQ(4), .ADDR_WIDTH(9), .DATA_WIDTH(64), .BRAM_LATENCY(2), .CNT_WIDTH(32)) u_b (
    .clk_i(clk), .rst_i(rst_n), .enable_i(b_en), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_addr_i(b_addr), .resp_valid_o(b_resp_valid), .resp_data_o(b_resp_data),
    .bram_r_addr_o(b_bram_addr), .bram_r_valid_o(b_bram_valid), .bram_r_i(b_bram_r)
`ifdef BRAM_ARB_STALL_COUNT_EN
    , .stall_count_o(b_stall)
`endif
  );

  bram_read_arbiter #(.N_REQ(2), .ADDR_WIDTH(9), .DATA_WIDTH(64), .BRAM_LATENCY(3), .CNT_WIDTH(32)) u_c (
    .clk_i(clk), .rst_i(rst_n), .enable_i(c_en), .req_valid_i(c_valid), .req_ready_o(c_ready),
    .req_addr_i(c_addr), .resp_valid_o(c_resp_valid), .resp_data_o(c_resp_data),
    .bram_r_addr_o(c_bram_addr), .bram_r_valid_o(c_bram_valid), .bram_r_i(c_bram_r)
`ifdef BRAM_ARB_STALL_COUNT_EN
    , .stall_count_o(c_stall)
`endif
  );

  // Inputs change 1ns after the rising edge; checks run 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_en = 1'b1; a_valid = '0; a_addr = '0;
    b_en = 1'b1; b_valid = '0; b_addr = '0;
    c_en = 1'b1; c_valid = '0; c_addr = '0;
    tick(); tick(); #1;
    checks++; if (a_resp_valid !== 2'b00) begin errors++; $display("FAIL reset_a_resp_valid got=%b want=00", a_resp_valid); end
    checks++; if (a_bram_valid !== 1'b0) begin errors++; $display("FAIL reset_a_bram_valid got=%b want=0", a_bram_valid); end
    checks++; if (a_ready !== 2'b00) begin errors++; $display("FAIL reset_a_ready got=%b want=00", a_ready); end
    checks++; if (b_resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_b_resp_valid got=%b want=0000", b_resp_valid); end
    checks++; if (c_resp_valid !== 2'b00) begin errors++; $display("FAIL reset_c_resp_valid got=%b want=00", c_resp_valid); end
`ifdef BRAM_ARB_STALL_COUNT_EN
    checks++; if (a_stall !== 32'd0) begin errors++; $display("FAIL reset_a_stall got=%0d want=0", a_stall); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    tick();
    a_valid = 2'b10; a_addr = {9'h005, 9'h1FF};
    #1;
    checks++; if (a_ready !== 2'b10) begin errors++; $display("FAIL single_ready got=%b want=10", a_ready); end
    checks++; if (a_bram_valid !== 1'b1) begin errors++; $display("FAIL single_bram_valid got=%b want=1", a_bram_valid); end
    checks++; if (a_bram_addr !== 9'h005) begin errors++; $display("FAIL single_bram_addr got=%h want=005", a_bram_addr); end
    tick();
    a_valid = 2'b00;
    #1;
    checks++; if (a_resp_valid !== 2'b10) begin errors++; $display("FAIL single_resp_valid got=%b want=10", a_resp_valid); end
    checks++; if (a_resp_data !== 64'hDEAD_BEEF_0000_0005) begin errors++; $display("FAIL single_resp_data got=%h want=deadbeef00000005", a_resp_data); end
    tick(); #1;
    checks++; if (a_resp_valid !== 2'b00) begin errors++; $display("FAIL single_resp_idle got=%b want=00", a_resp_valid); end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_g, prev_g;
    logic [8:0]  exp_a;
    logic [63:0] prev_d;
    a_addr = {9'h011, 9'h010};
    for (int c = 0; c < 6; c++) begin
      tick();
      a_valid = 2'b11;
      #1;
      exp_g  = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_a  = (c % 2 == 0) ? 9'h010 : 9'h011;
      prev_g = (c % 2 == 0) ? 2'b10 : 2'b01;
      prev_d = (c % 2 == 0) ? 64'hDEAD_BEEF_0000_0011 : 64'hDEAD_BEEF_0000_0010;
      checks++; if (a_ready !== exp_g) begin errors++; $display("FAIL fair_ready c=%0d got=%b want=%b", c, a_ready, exp_g); end
      checks++; if (a_bram_addr !== exp_a) begin errors++; $display("FAIL fair_addr c=%0d got=%h want=%h", c, a_bram_addr, exp_a); end
      if (c > 0) begin
        checks++; if (a_resp_valid !== prev_g) begin errors++; $display("FAIL fair_resp_valid c=%0d got=%b want=%b", c, a_resp_valid, prev_g); end
        checks++; if (a_resp_data !== prev_d) begin errors++; $display("FAIL fair_resp_data c=%0d got=%h want=%h", c, a_resp_data, prev_d); end
      end
    end
    tick();
    a_valid = 2'b00;
    #1;
    checks++; if (a_resp_valid !== 2'b10) begin errors++; $display("FAIL fair_last_resp got=%b want=10", a_resp_valid); end
    checks++; if (a_resp_data !== 64'hDEAD_BEEF_0000_0011) begin errors++; $display("FAIL fair_last_data got=%h want=deadbeef00000011", a_resp_data); end
`ifdef BRAM_ARB_STALL_COUNT_EN
    checks++; if (a_stall !== 32'd6) begin errors++; $display("FAIL fair_stall got=%0d want=6", a_stall); end
`endif
  endtask

  task automatic test_wrap_skip();
    logic [3:0]  eg [6];
    logic [63:0] ed [6];
    eg = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
    ed = '{64'hDEAD_BEEF_0000_0101, 64'hDEAD_BEEF_0000_0103, 64'hDEAD_BEEF_0000_0101,
           64'hDEAD_BEEF_0000_0103, 64'h0, 64'h0};
    b_addr = {9'h103, 9'h102, 9'h101, 9'h100};
    for (int c = 0; c < 6; c++) begin
      tick();
      b_valid = (c < 4) ? 4'b1010 : 4'b0000;
      #1;
      checks++; if (b_ready !== eg[c]) begin errors++; $display("FAIL wrap_ready c=%0d got=%b want=%b", c, b_ready, eg[c]); end
      if (eg[c] != 4'b0000) begin
        checks++; if (b_bram_addr !== ed[c][8:0]) begin errors++; $display("FAIL wrap_addr c=%0d got=%h want=%h", c, b_bram_addr, ed[c][8:0]); end
      end
      if (c >= 2) begin
        checks++; if (b_resp_valid !== eg[c-2]) begin errors++; $display("FAIL wrap_resp_valid c=%0d got=%b want=%b", c, b_resp_valid, eg[c-2]); end
        if (eg[c-2] != 4'b0000) begin
          checks++; if (b_resp_data !== ed[c-2]) begin errors++; $display("FAIL wrap_resp_data c=%0d got=%h want=%h", c, b_resp_data, ed[c-2]); end
        end
      end
    end
`ifdef BRAM_ARB_STALL_COUNT_EN
    checks++; if (b_stall !== 32'd4) begin errors++; $display("FAIL wrap_stall got=%0d want=4", b_stall); end
`endif
  endtask

  task automatic test_enable_drop();
    tick();
    b_en = 1'b1; b_valid = 4'b0001;
    #1;
    checks++; if (b_ready !== 4'b0001) begin errors++; $display("FAIL en_grant0 got=%b want=0001", b_ready); end
    tick();
    b_en = 1'b0; b_valid = 4'b0010;
    #1;
    checks++; if (b_ready !== 4'b0000) begin errors++; $display("FAIL en_off_ready1 got=%b want=0000", b_ready); end
    checks++; if (b_bram_valid !== 1'b0) begin errors++; $display("FAIL en_off_bram_valid got=%b want=0", b_bram_valid); end
    checks++; if (b_resp_valid !== 4'b0000) begin errors++; $display("FAIL en_off_resp1 got=%b want=0000", b_resp_valid); end
`ifdef BRAM_ARB_STALL_COUNT_EN
    checks++; if (b_stall !== 32'd4) begin errors++; $display("FAIL en_stall_t1 got=%0d want=4", b_stall); end
`endif
    tick(); #1;
    checks++; if (b_ready !== 4'b0000) begin errors++; $display("FAIL en_off_ready2 got=%b want=0000", b_ready); end
    checks++; if (b_resp_valid !== 4'b0001) begin errors++; $display("FAIL en_drain_resp got=%b want=0001", b_resp_valid); end
    checks++; if (b_resp_data !== 64'hDEAD_BEEF_0000_0100) begin errors++; $display("FAIL en_drain_data got=%h want=deadbeef00000100", b_resp_data); end
`ifdef BRAM_ARB_STALL_COUNT_EN
    checks++; if (b_stall !== 32'd5) begin errors++; $display("FAIL en_stall_t2 got=%0d want=5", b_stall); end
`endif
    tick(); #1;
    checks++; if (b_ready !== 4'b0000) begin errors++; $display("FAIL en_off_ready3 got=%b want=0000", b_ready); end
    checks++; if (b_resp_valid !== 4'b0000) begin errors++; $display("FAIL en_off_resp3 got=%b want=0000", b_resp_valid); end
    tick();
    b_en = 1'b1;
    #1;
    checks++; if (b_ready !== 4'b0010) begin errors++; $display("FAIL en_on_ready got=%b want=0010", b_ready); end
    checks++; if (b_bram_addr !== 9'h101) begin errors++; $display("FAIL en_on_addr got=%h want=101", b_bram_addr); end
`ifdef BRAM_ARB_STALL_COUNT_EN
    checks++; if (b_stall !== 32'd7) begin errors++; $display("FAIL en_stall_t4 got=%0d want=7", b_stall); end
`endif
    tick();
    b_valid = 4'b0000;
    #1;
    checks++; if (b_resp_valid !== 4'b0000) begin errors++; $display("FAIL en_resp_t5 got=%b want=0000", b_resp_valid); end
`ifdef BRAM_ARB_STALL_COUNT_EN
    checks++; if (b_stall !== 32'd7) begin errors++; $display("FAIL en_stall_t5 got=%0d want=7", b_stall); end
`endif
    tick(); #1;
    checks++; if (b_resp_valid !== 4'b0010) begin errors++; $display("FAIL en_resp_t6 got=%b want=0010", b_resp_valid); end
    checks++; if (b_resp_data !== 64'hDEAD_BEEF_0000_0101) begin errors++; $display("FAIL en_data_t6 got=%h want=deadbeef00000101", b_resp_data); end
  endtask

  task automatic test_reset_midflight();
    c_addr = {9'h021, 9'h020};
    tick();
    c_valid = 2'b01;
    #1;
    checks++; if (c_ready !== 2'b01) begin errors++; $display("FAIL mid_grant got=%b want=01", c_ready); end
    tick();
    c_valid = 2'b00; rst_n = 1'b0;
    #1;
    checks++; if (c_resp_valid !== 2'b00) begin errors++; $display("FAIL mid_resp_t1 got=%b want=00", c_resp_valid); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (c_resp_valid !== 2'b00) begin errors++; $display("FAIL mid_resp_t2 got=%b want=00", c_resp_valid); end
    tick();
    c_valid = 2'b11;
    #1;
    checks++; if (c_resp_valid !== 2'b00) begin errors++; $display("FAIL mid_dropped_resp got=%b want=00", c_resp_valid); end
    checks++; if (c_ready !== 2'b01) begin errors++; $display("FAIL mid_first_after_reset got=%b want=01", c_ready); end
    tick(); #1;
    checks++; if (c_ready !== 2'b10) begin errors++; $display("FAIL mid_second_grant got=%b want=10", c_ready); end
    checks++; if (c_resp_valid !== 2'b00) begin errors++; $display("FAIL mid_resp_t4 got=%b want=00", c_resp_valid); end
    tick();
    c_valid = 2'b00;
    #1;
    checks++; if (c_resp_valid !== 2'b00) begin errors++; $display("FAIL mid_resp_t5 got=%b want=00", c_resp_valid); end
`ifdef BRAM_ARB_STALL_COUNT_EN
    checks++; if (c_stall !== 32'd2) begin errors++; $display("FAIL mid_stall got=%0d want=2", c_stall); end
`endif
    tick(); #1;
    checks++; if (c_resp_valid !== 2'b01) begin errors++; $display("FAIL mid_resp_t6 got=%b want=01", c_resp_valid); end
    checks++; if (c_resp_data !== 64'hDEAD_BEEF_0000_0020) begin errors++; $display("FAIL mid_data_t6 got=%h want=deadbeef00000020", c_resp_data); end
    tick(); #1;
    checks++; if (c_resp_valid !== 2'b10) begin errors++; $display("FAIL mid_resp_t7 got=%b want=10", c_resp_valid); end
    checks++; if (c_resp_data !== 64'hDEAD_BEEF_0000_0021) begin errors++; $display("FAIL mid_data_t7 got=%h want=deadbeef00000021", c_resp_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap_skip();
    test_enable_drop();
    test_reset_midflight();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
